// File: rtl/axis_frame_aligner.sv
// axis_frame_aligner: regenerates exact WIDTH x HEIGHT AXI4-Stream framing by padding, truncating and SOF hunting.
// Optional FRAME_ALIGN_STATS_EN adds saturating counters for short lines, long lines and short frames.
module axis_frame_aligner #(
   parameter int WIDTH = 32,
   parameter int HEIGHT = 16,
   parameter int DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic                  frame_err
`ifdef FRAME_ALIGN_STATS_EN
   ,
   output logic [15:0]           cnt_short_line,
   output logic [15:0]           cnt_long_line,
   output logic [15:0]           cnt_short_frame
`endif
);

   localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [2:0] {WAIT_SOF, PASS, PAD_LINE, DROP, PAD_FRAME} state_t;

   state_t                state;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic                  out_free;
   logic                  at_origin;
   logic                  last_x;
   logic                  last_y;
   logic                  accept;
   logic                  emit;
   logic                  fwd;
   logic [DATA_WIDTH-1:0] emit_data;
   logic                  ev_short_line;
   logic                  ev_long_line;
   logic                  ev_short_frame;

   assign out_free  = !m_axis_tvalid || m_axis_tready;
   assign at_origin = (x == '0) && (y == '0);
   assign last_x    = (x == XW'(WIDTH - 1));
   assign last_y    = (y == YW'(HEIGHT - 1));

   // An SOF beat is only taken when the output register can hold it; a mid-frame SOF is held off entirely.
   always_comb begin
      s_axis_tready = 1'b0;
      if (rst_n) begin
         case (state)
            WAIT_SOF: s_axis_tready = out_free || !s_axis_tuser;
            PASS:     s_axis_tready = out_free && (!s_axis_tuser || at_origin);
            DROP:     s_axis_tready = !s_axis_tuser;
            default:  s_axis_tready = 1'b0;
         endcase
      end
   end

   assign accept = s_axis_tvalid && s_axis_tready;

   always_comb begin
      emit      = 1'b0;
      fwd       = 1'b0;
      emit_data = PAD_VALUE;
      case (state)
         WAIT_SOF: begin
            fwd       = accept && s_axis_tuser;
            emit      = fwd;
            emit_data = s_axis_tdata;
         end
         PASS: begin
            fwd       = accept;
            emit      = fwd;
            emit_data = s_axis_tdata;
         end
         PAD_LINE, PAD_FRAME: emit = out_free;
         default: emit = 1'b0;
      endcase
      ev_short_line  = fwd && s_axis_tlast && !last_x;
      ev_long_line   = fwd && !s_axis_tlast && last_x;
      ev_short_frame = s_axis_tvalid && s_axis_tuser &&
                       (((state == PASS) && !at_origin) || ((state == DROP) && (y != '0)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= WAIT_SOF;
         x             <= '0;
         y             <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         frame_err <= ev_short_line || ev_long_line || ev_short_frame;
         if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= emit_data;
            m_axis_tlast  <= last_x;
            m_axis_tuser  <= at_origin;
            if (last_x) begin
               x <= '0;
               y <= last_y ? '0 : y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end
         case (state)
            WAIT_SOF, PASS: begin
               if (ev_short_frame) begin
                  state <= PAD_FRAME;
               end else if (fwd) begin
                  if (ev_short_line) begin
                     state <= PAD_LINE;
                  end else if (ev_long_line) begin
                     state <= DROP;
                  end else if (last_x && last_y) begin
                     state <= WAIT_SOF;
                  end else begin
                     state <= PASS;
                  end
               end
            end
            PAD_LINE: begin
               if (emit && last_x) begin
                  state <= last_y ? WAIT_SOF : PASS;
               end
            end
            // Counters already wrapped on the truncated beat, so y==0 here means the frame is complete.
            DROP: begin
               if (ev_short_frame) begin
                  state <= PAD_FRAME;
               end else if (s_axis_tvalid && (s_axis_tuser || s_axis_tlast)) begin
                  state <= (y == '0) ? WAIT_SOF : PASS;
               end
            end
            PAD_FRAME: begin
               if (emit && last_x && last_y) begin
                  state <= WAIT_SOF;
               end
            end
            default: state <= WAIT_SOF;
         endcase
      end
   end

`ifdef FRAME_ALIGN_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_short_line  <= '0;
         cnt_long_line   <= '0;
         cnt_short_frame <= '0;
      end else begin
         if (ev_short_line && (cnt_short_line != 16'hFFFF)) begin
            cnt_short_line <= cnt_short_line + 16'd1;
         end
         if (ev_long_line && (cnt_long_line != 16'hFFFF)) begin
            cnt_long_line <= cnt_long_line + 16'd1;
         end
         if (ev_short_frame && (cnt_short_frame != 16'hFFFF)) begin
            cnt_short_frame <= cnt_short_frame + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/axis_frame_aligner.md
# axis_frame_aligner

Upstream conditioning stage for `barrel_distortion_correction`. Takes a loosely framed AXI4-Stream video feed and emits exactly HEIGHT lines of exactly WIDTH pixels per frame. Output `tuser` marks the first pixel of each frame and output `tlast` marks the last pixel of each line. Short lines and frames are padded, long lines are truncated, and beats before the first start-of-frame are discarded, so the correction stage's line counters never desynchronise.

## Interface
Parameters:
- `WIDTH`, 32, active pixels per line.
- `HEIGHT`, 16, lines per frame.
- `DATA_WIDTH`, 8, pixel width.
- `PAD_VALUE`, 0, pixel value inserted when padding.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock.
- `rst_n`  in  1  synchronous active-low reset.
- `s_axis_tdata`  in  DATA_WIDTH  input pixel.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tlast`  in  1  input end-of-line.
- `s_axis_tuser`  in  1  input start-of-frame.
- `s_axis_tready`  out  1  input ready (combinational from state and output register).
- `m_axis_tdata`  out  DATA_WIDTH  output pixel.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tlast`  out  1  regenerated end-of-line.
- `m_axis_tuser`  out  1  regenerated start-of-frame.
- `m_axis_tready`  in  1  output ready.
- `frame_err`  out  1  one-cycle pulse on any framing correction.

## Operation
- Counters: `x` (0..WIDTH-1) and `y` (0..HEIGHT-1) track the next output pixel. An output beat is emitted when the output register loads.
- Output flags per emitted beat:
  - `tuser` = (x==0 && y==0).
  - `tlast` = (x==WIDTH-1).
  - Input `tlast`/`tuser` never pass through directly.
- State WAIT_SOF (reset state):
  - `s_axis_tready`=1.
  - Beats with `tuser`=0 are discarded.
  - A beat with `tuser`=1 is forwarded as pixel (0,0); go to PASS.
- State PASS:
  - `s_axis_tready` = !m_axis_tvalid || m_axis_tready.
  - Each accepted beat is forwarded.
  - Early line end: input `tlast`=1 at x<WIDTH-1. Forward the beat, pulse `frame_err`, go to PAD_LINE.
  - Long line: x==WIDTH-1 with input `tlast`=0. Forward the beat, go to DROP.
  - Mid-frame SOF: input `tuser`=1 when not at (0,0). Do not consume the beat; pulse `frame_err`; go to PAD_FRAME.
  - After pixel (WIDTH-1,HEIGHT-1) with input `tlast`=1, go to WAIT_SOF.
- State PAD_LINE:
  - `s_axis_tready`=0.
  - Emit PAD_VALUE until the x==WIDTH-1 beat is emitted.
  - Then go to PASS, or to WAIT_SOF if that was the frame's last line.
- State DROP:
  - `s_axis_tready`=1.
  - Discard beats up to and including the first `tlast`=1 beat; pulse `frame_err` once on entry.
  - Then go to PASS, or to WAIT_SOF if the frame is complete.
  - A `tuser`=1 beat seen in DROP is not consumed; go to PAD_FRAME, or to WAIT_SOF if the frame is complete.
- State PAD_FRAME:
  - `s_axis_tready`=0.
  - Emit PAD_VALUE through pixel (WIDTH-1,HEIGHT-1), then go to WAIT_SOF.
  - The held SOF beat is then accepted immediately.
- Simultaneous input `tuser`=1 and `tlast`=1 in WAIT_SOF with WIDTH>1: treat as SOF plus early line end.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0.
  - `frame_err`=0; `s_axis_tready`=0 while `rst_n`=0.
  - State WAIT_SOF; x=y=0.
- Reset mid-frame discards the partial frame. No padding is emitted.
- Latency: accepted beat appears on `m_axis_*` the next cycle. Pad beats are issued one per cycle when the output register is free.
- Output register: holds data and flags stable while `m_axis_tvalid`=1 && `m_axis_tready`=0. Full throughput of 1 pixel/cycle when `m_axis_tready`=1.
- `frame_err` is registered and asserted one cycle after the offending beat or decision.

## Configuration
- `FRAME_ALIGN_STATS_EN` defined:
  - Adds outputs `cnt_short_line`, `cnt_long_line`, `cnt_short_frame`, each 16-bit, saturating at 0xFFFF, cleared by reset.
  - Each increments once per corresponding event (entry to PAD_LINE, DROP, PAD_FRAME).
- Not defined: those ports and their counters are absent. `frame_err` is unchanged.

## Test plan
All scenarios use WIDTH=8, HEIGHT=4.
- Clean frame of 32 beats with correct `tuser`/`tlast`, `m_axis_tready`=1 → 32 outputs identical to input, `tuser` on beat 0, `tlast` on beats 7/15/23/31, 1-cycle latency, `frame_err` never set.
- Three beats with `tuser`=0 before the SOF → the three beats are discarded; output starts at the SOF beat.
- Line 1 ends with `tlast` after 5 pixels → 3 PAD_VALUE beats, the last with `tlast`=1; `frame_err` pulses once; line 2 aligned.
- Line 0 carries 11 pixels → 8 forwarded, 3 dropped, `frame_err` pulses once, next line starts at x=0.
- New SOF arrives at (3,2) → 13 pad beats complete the frame; next frame starts from the held SOF beat with `tuser`=1.
- Random `m_axis_tready` (50%) on a clean frame → no beat lost or duplicated; data held stable under backpressure. With `FRAME_ALIGN_STATS_EN` defined, all counters remain 0.
